instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Prefetching instruction-fetch stage for OSECPU, directly upstream of the decode stage. Issues sequential 32-bit instruction reads to the synchronous `Memory` block, buffers returned words with their PCs in a small FIFO, and presents them to decode via a valid/ready handshake. A redirect input (jump/branch) flushes buffered and in-flight instructions and restarts fetch at a new address.

## Interface
Parameters:
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥ 2.
- `RESET_PC`, 16'h0000: first fetch address after reset.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_addr`  out  16  word address to `Memory`; equals internal fetch PC.
- `mem_req`  out  1  a read is issued at `mem_addr` this cycle.
- `mem_data`  in  32  read data; valid the cycle after the matching `mem_req`.
- `jump_en`  in  1  redirect request from decode/execute, one-cycle pulse.
- `jump_addr`  in  16  redirect target.
- `instr`  out  32  FIFO head instruction word.
- `instr_pc`  out  16  address `instr` was fetched from.
- `instr_valid`  out  1  `instr`/`instr_pc` valid.
- `instr_ready`  in  1  decode accepts head this cycle.

## Operation
- State: `fetch_pc` (16b), `inflight` (1b, a read issued last cycle, not yet returned), `inflight_pc` (16b), FIFO of `DEPTH` × {32b word, 16b pc}, `count` (0..DEPTH).
- Pop: `pop = instr_valid & instr_ready`. Head advances on pop.
- Issue: `mem_req = !jump_en & (count + inflight - pop < DEPTH)`. On issue: `inflight <= 1`, `inflight_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 1` (16-bit, 16'hFFFF wraps to 16'h0000). No issue: `inflight <= 0`.
- Return: if `inflight` and no `jump_en`, `{mem_data, inflight_pc}` written to FIFO tail this edge.
- Simultaneous push and pop: `count` unchanged, both take effect. The credit rule guarantees push never overflows the FIFO.
- Redirect (`jump_en=1`): highest priority.
  - FIFO emptied (`count <= 0`).
  - Any returning in-flight word discarded.
  - Pop that cycle ignored for state (decode must not consume head with a jump asserted).
  - `mem_req = 0`, `inflight <= 0`, `fetch_pc <= jump_addr`.
- `instr_valid = (count != 0)`. `instr`/`instr_pc` show FIFO head (first-word-fall-through). Both hold value while `instr_valid` and not `instr_ready`.
- Reset (any time, including mid-burst or mid-redirect):
  - `fetch_pc = RESET_PC`, `count = 0`, `inflight = 0`.
  - Outputs: `instr_valid=0`, `instr=0`, `instr_pc=0`, `mem_req=0`, `mem_addr=RESET_PC`.
  - After deassert, first issue in the first clock cycle.

## Timing
- `Memory` read latency is 1 cycle: address issued in cycle N, `mem_data` sampled at the end of cycle N+1.
- First instruction: issue in cycle 0 after reset release, data written end of cycle 1, `instr_valid=1` in cycle 2.
- Redirect: `jump_en` in cycle J.
  - Target issued in cycle J+1.
  - Target instruction valid in cycle J+3.
  - `instr_valid=0` in J+1 and J+2.
- Steady state with `instr_ready` held high: one instruction per cycle, no bubbles, for `DEPTH ≥ 2`.
- Backpressure: with `instr_ready=0`, issue stops once `count + inflight = DEPTH`. FIFO ends exactly full. No word is lost or duplicated.
- Combinational paths: `instr_ready`/`jump_en` → `mem_req` only. No combinational path from inputs to `instr_valid`, `instr` or `instr_pc`.

## Test plan
- Reset then stream: memory[i]=32'hA000_0000+i, `instr_ready=1`. Expect `instr_valid` rises in cycle 2. Then `instr_pc`=0,1,2,… with matching words, one per cycle.
- Backpressure: `instr_ready=0` for 10 cycles. Expect `mem_req` stops after `DEPTH` issues and `count=4`. Release: PCs 0..3 followed by 4,5… with no gap or duplicate.
- Redirect with in-flight read: while streaming, pulse `jump_en`, `jump_addr=16'h0100`. Expect old in-flight word dropped, `instr_valid=0` for 2 cycles, then `instr_pc`=0x0100, 0x0101…
- Jump with FIFO full and `instr_ready=1` same cycle: expect FIFO flushed, no pop effect, next valid `instr_pc`=jump target.
- Wrap: `jump_addr=16'hFFFE`. Expect `instr_pc` sequence FFFE, FFFF, 0000, 0001.
- Async reset mid-burst (asserted between edges): outputs immediately zero/`RESET_PC`. After release, fetch restarts at `RESET_PC` with the 2-cycle first-valid latency.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Prefetching instruction-fetch stage: issues sequential reads to a 1-cycle Memory,
// buffers {word, pc} in a FIFO and hands them to decode; jump_en flushes and redirects.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    input  logic [31:0] mem_data,
    input  logic        jump_en,
    input  logic [15:0] jump_addr,
    output logic [31:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [15:0]      fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [15:0]      inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      word_q [DEPTH];
    logic [15:0]      pc_q   [DEPTH];

    logic             pop;
    logic             push;
    logic [CNT_W:0]   credit;

    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? word_q[rd_ptr_q] : 32'h0;
    assign instr_pc    = instr_valid ? pc_q[rd_ptr_q]   : 16'h0;
    assign mem_addr    = fetch_pc_q;

    // Slots already committed (buffered + in flight, minus the one leaving) gate the next issue.
    assign pop     = instr_valid & instr_ready;
    assign push    = inflight_q & ~jump_en;
    assign credit  = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign mem_req = ~reset & ~jump_en & (credit < (CNT_W+1)'(DEPTH));

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (jump_en) begin
            fetch_pc_d = jump_addr;
            inflight_d = 1'b0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            inflight_d = mem_req;
            if (mem_req) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 16'd1;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 16'h0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr_q] <= mem_data;
            pc_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed latency/redirect/backpressure scenarios
// plus a randomized run scored against an in-order PC-stream model.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic [31:0] mem_data;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_data   (mem_data),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return 32'hA000_0000 + {16'h0, a};
    endfunction

    // Memory model: 1-cycle read latency, garbage when no read was issued.
    always @(posedge clk) mem_data <= mem_req ? mem_word(mem_addr) : $urandom;

    // Drive one cycle's inputs at the falling edge, then settle before sampling.
    task automatic drive(input logic rdy, input logic jen, input logic [15:0] ja);
        @(negedge clk);
        instr_ready = rdy;
        jump_en     = jen;
        jump_addr   = ja;
        #1;
    endtask

    // Ends sampling cycle 0 after release.
    task automatic do_reset(input logic rdy);
        reset = 1'b1; jump_en = 1'b0; jump_addr = 16'h0; instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        instr_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; jump_en = 1'b0; jump_addr = 16'h1234; instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_checks++; if (instr_pc !== 16'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req); end
        n_checks++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0) begin n_fail++; $display("FAIL stream_c0_issue: got req=%b addr=%h want req=1 addr=0000", mem_req, mem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c0_valid: got %b want 0", instr_valid); end
        drive(1'b1, 1'b0, 16'h0);
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c1_valid: got %b want 0", instr_valid); end
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b0, 16'h0);
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'(k) || instr !== mem_word(16'(k))) begin
                n_fail++; $display("FAIL stream_word%0d: got v=%b pc=%h w=%h want v=1 pc=%h w=%h", k, instr_valid, instr_pc, instr, 16'(k), mem_word(16'(k)));
            end
        end
    endtask

    task automatic test_backpressure();
        int issues;
        do_reset(1'b0);
        issues = int'(mem_req);
        for (int c = 1; c < 10; c++) begin
            drive(1'b0, 1'b0, 16'h0);
            issues += int'(mem_req);
        end
        n_checks++; if (issues != DEPTH) begin n_fail++; $display("FAIL bp_issue_count: got %0d want %0d", issues, DEPTH); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_stopped: got %b want 0", mem_req); end
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0) begin n_fail++; $display("FAIL bp_head_held: got v=%b pc=%h want v=1 pc=0000", instr_valid, instr_pc); end
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b0, 16'h0);
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'(k) || instr !== mem_word(16'(k))) begin
                n_fail++; $display("FAIL bp_release%0d: got v=%b pc=%h w=%h want v=1 pc=%h", k, instr_valid, instr_pc, instr, 16'(k));
            end
        end
    endtask

    // Redirect in the next cycle, then check the J+1..J+3 timing and the first four target words.
    task automatic test_jump_to(input string name, input logic [15:0] target, input logic rdy_j);
        logic [15:0] e;
        drive(rdy_j, 1'b1, target);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL %s_jreq: got %b want 0", name, mem_req); end
        drive(1'b1, 1'b0, 16'h0);
        n_checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== target) begin
            n_fail++; $display("FAIL %s_j1: got v=%b req=%b addr=%h want v=0 req=1 addr=%h", name, instr_valid, mem_req, mem_addr, target);
        end
        drive(1'b1, 1'b0, 16'h0);
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL %s_j2: got v=%b want 0", name, instr_valid); end
        for (int k = 0; k < 4; k++) begin
            e = target + 16'(k);
            drive(1'b1, 1'b0, 16'h0);
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== e || instr !== mem_word(e)) begin
                n_fail++; $display("FAIL %s_seq%0d: got v=%b pc=%h w=%h want v=1 pc=%h w=%h", name, k, instr_valid, instr_pc, instr, e, mem_word(e));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1);
        drive(1'b1, 1'b0, 16'h0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 16'h0);
            n_checks++; if (instr_pc !== 16'(k)) begin n_fail++; $display("FAIL redir_pre%0d: got %h want %h", k, instr_pc, 16'(k)); end
        end
        test_jump_to("redir", 16'h0100, 1'b1);
    endtask

    task automatic test_jump_full();
        do_reset(1'b0);
        repeat (8) drive(1'b0, 1'b0, 16'h0);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0) begin n_fail++; $display("FAIL jfull_pre: got v=%b pc=%h want v=1 pc=0000", instr_valid, instr_pc); end
        test_jump_to("jfull", 16'h0200, 1'b1);
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        drive(1'b1, 1'b0, 16'h0);
        test_jump_to("wrap", 16'hFFFE, 1'b0);
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        repeat (4) drive(1'b1, 1'b0, 16'h0);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 16'h0) begin
            n_fail++; $display("FAIL areset_out: got v=%b w=%h pc=%h want 0/0/0", instr_valid, instr, instr_pc);
        end
        n_checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0) begin n_fail++; $display("FAIL areset_mem: got req=%b addr=%h want 0/0000", mem_req, mem_addr); end
        do_reset(1'b1);
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0) begin n_fail++; $display("FAIL areset_c0: got req=%b addr=%h want 1/0000", mem_req, mem_addr); end
        drive(1'b1, 1'b0, 16'h0);
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL areset_c1: got v=%b want 0", instr_valid); end
        drive(1'b1, 1'b0, 16'h0);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0 || instr !== mem_word(16'h0)) begin
            n_fail++; $display("FAIL areset_c2: got v=%b pc=%h w=%h want v=1 pc=0000", instr_valid, instr_pc, instr);
        end
    endtask

    // Model: decode sees the PC stream start, start+1, ... restarting at each jump target.
    task automatic test_random();
        logic [15:0] exp_pc;
        logic        r, j;
        logic [15:0] a;
        int          since_jump;
        int          pops;
        exp_pc = 16'h0; since_jump = 99; pops = 0;
        do_reset(1'b0);
        for (int c = 0; c < 500; c++) begin
            r = ($urandom_range(0, 3) != 0);
            j = ($urandom_range(0, 24) == 0);
            a = 16'($urandom);
            drive(r, j, a);
            since_jump++;
            if (since_jump == 1 || since_jump == 2) begin
                n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_bubble c%0d: got v=%b want 0", c, instr_valid); end
            end
            if (since_jump == 3) begin
                n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_target c%0d: got v=%b want 1", c, instr_valid); end
            end
            if (instr_valid === 1'b1 && r && !j) begin
                n_checks++;
                if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL rnd_pop c%0d: got pc=%h w=%h want pc=%h w=%h", c, instr_pc, instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 16'd1;
                pops++;
            end
            if (j) begin
                exp_pc = a;
                since_jump = 0;
            end
        end
        n_checks++; if (pops < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d pops want >= 100", pops); end
    endtask

    initial begin
        reset = 1'b1; jump_en = 1'b0; jump_addr = 16'h0; instr_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_jump_full();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
